// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit in front of a word-wide data memory.
// Sub-word stores are done as read-modify-write; the memory is big-endian.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_dataIn,
  output logic              mem_we,
  input  logic [31:0]       mem_dataOut
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR, DONE} state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign busy = (state != IDLE);

  always_comb begin
    misaligned = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
      OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
      default:              misaligned = 1'b0;
    endcase
  end

  // Offset 0 is the most significant byte of the word.
  always_comb begin
    byte_sel = 8'h00;
    case (off_q)
      2'd0: byte_sel = mem_dataOut[31:24];
      2'd1: byte_sel = mem_dataOut[23:16];
      2'd2: byte_sel = mem_dataOut[15:8];
      2'd3: byte_sel = mem_dataOut[7:0];
      default: byte_sel = 8'h00;
    endcase
    half_sel = off_q[1] ? mem_dataOut[15:0] : mem_dataOut[31:16];

    load_val = mem_dataOut;
    case (op_q)
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LBU:  load_val = {24'h000000, byte_sel};
      OP_LHU:  load_val = {16'h0000, half_sel};
      default: load_val = mem_dataOut;
    endcase

    merged = mem_dataOut;
    if (op_q == OP_SH) begin
      if (off_q[1]) merged[15:0]  = wdata_q;
      else          merged[31:16] = wdata_q;
    end else begin
      case (off_q)
        2'd0: merged[31:24] = wdata_q[7:0];
        2'd1: merged[23:16] = wdata_q[7:0];
        2'd2: merged[15:8]  = wdata_q[7:0];
        2'd3: merged[7:0]   = wdata_q[7:0];
        default: merged = mem_dataOut;
      endcase
    end
  end

  // done and mem_we are single-cycle pulses, cleared by default every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= 3'b000;
      off_q       <= 2'b00;
      wdata_q     <= 16'h0000;
      rdata       <= 32'h0;
      done        <= 1'b0;
      err         <= 1'b0;
      mem_address <= '0;
      mem_dataIn  <= 32'h0;
      mem_we      <= 1'b0;
    end else begin
      done   <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem_address <= addr[ADDR_W+1:2];
            off_q       <= addr[1:0];
            op_q        <= op;
            wdata_q     <= wdata[15:0];
            err         <= misaligned;
            if (misaligned) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (op == OP_SW) begin
              state      <= WR;
              mem_we     <= 1'b1;
              mem_dataIn <= wdata;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: state <= RD_DATA;
        RD_DATA: begin
          if (op_q == OP_SB || op_q == OP_SH) begin
            state      <= WR;
            mem_we     <= 1'b1;
            mem_dataIn <= merged;
          end else begin
            rdata <= load_val;
            state <= DONE;
            done  <= 1'b1;
          end
        end
        WR: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes the expected completion,
// a negedge monitor pops and compares whenever done pulses.
module tb_load_store_unit;

  localparam int ADDR_W = 10;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [2:0]        op = 3'b000;
  logic [ADDR_W+1:0] addr = '0;
  logic [31:0]       wdata = 32'h0;
  logic [31:0]       rdata;
  logic              done;
  logic              busy;
  logic              err;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_dataIn;
  logic              mem_we;
  logic [31:0]       mem_dataOut;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    int          tag;
  } exp_t;

  exp_t expq[$];
  exp_t e;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int weCount = 0;
  int doneCount = 0;
  int tagCnt = 0;
  int doneBefore;
  int baseCyc;
  logic [ADDR_W-1:0] lastWeAddr = '0;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .done        (done),
    .busy        (busy),
    .err         (err),
    .mem_address (mem_address),
    .mem_dataIn  (mem_dataIn),
    .mem_we      (mem_we),
    .mem_dataOut (mem_dataOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Data memory: synchronous write, read data valid one cycle after the address.
  always @(posedge clk) begin
    if (mem_we) mem[mem_address] <= mem_dataIn;
    mem_dataOut <= mem[mem_address];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      weCount++;
      lastWeAddr = mem_address;
    end
    if (!rst && done) begin
      doneCount++;
      if (expq.size() == 0) begin
        checkOutput("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        e = expq.pop_front();
        checkOutput($sformatf("done_cycle[%0d]", e.tag), 32'(cycleCnt), 32'(e.cyc));
        checkOutput($sformatf("rdata[%0d]", e.tag), rdata, e.rdata);
        checkOutput($sformatf("err[%0d]", e.tag), {31'b0, err}, {31'b0, e.err});
      end
    end
  end

  // Called at a negedge while the DUT is idle; returns at the first idle negedge after done.
  task automatic applyStimulus(input logic [2:0] o, input logic [ADDR_W+1:0] a, input logic [31:0] wd,
                               input logic [31:0] expR, input logic expE, input int lat);
    int k;
    start = 1'b1;
    op    = o;
    addr  = a;
    wdata = wd;
    expq.push_back('{cycleCnt + lat, expR, expE, tagCnt});
    tagCnt++;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (!done) checkOutput("done_timeout", {31'b0, done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_rdata"}, rdata, 32'h0);
    checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, "_err"}, {31'b0, err}, 32'd0);
    checkOutput({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    checkOutput({tag, "_mem_address"}, 32'(mem_address), 32'd0);
    checkOutput({tag, "_mem_dataIn"}, mem_dataIn, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    applyStimulus(OP_SW, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    checkOutput("sw_we_count", 32'(weCount), 32'd1);
    checkOutput("sw_we_addr", 32'(lastWeAddr), 32'd4);
    checkOutput("sw_mem4", mem[4], 32'hDEADBEEF);
    applyStimulus(OP_LW, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3);

    applyStimulus(OP_SB, 12'h011, 32'h00000055, 32'hDEADBEEF, 1'b0, 4);
    checkOutput("sb_we_count", 32'(weCount), 32'd2);
    checkOutput("sb_mem4", mem[4], 32'hDE55BEEF);
    applyStimulus(OP_LW, 12'h010, 32'h0, 32'hDE55BEEF, 1'b0, 3);

    applyStimulus(OP_LB,  12'h011, 32'h0, 32'h00000055, 1'b0, 3);
    applyStimulus(OP_LH,  12'h010, 32'h0, 32'hFFFFDE55, 1'b0, 3);
    applyStimulus(OP_LHU, 12'h010, 32'h0, 32'h0000DE55, 1'b0, 3);
    applyStimulus(OP_LBU, 12'h013, 32'h0, 32'h000000EF, 1'b0, 3);
    applyStimulus(OP_LB,  12'h010, 32'h0, 32'hFFFFFFDE, 1'b0, 3);
    applyStimulus(OP_LH,  12'h012, 32'h0, 32'hFFFFBEEF, 1'b0, 3);

    applyStimulus(OP_SH, 12'h022, 32'hABCD1234, 32'hFFFFBEEF, 1'b0, 4);
    checkOutput("sh_mem8", mem[8], 32'h00001234);
    applyStimulus(OP_SB, 12'h023, 32'hFFFFFF99, 32'hFFFFBEEF, 1'b0, 4);
    checkOutput("sb3_mem8", mem[8], 32'h00001299);
    applyStimulus(OP_LW, 12'h020, 32'h0, 32'h00001299, 1'b0, 3);

    applyStimulus(OP_LW,  12'h012, 32'h0,        32'h00001299, 1'b1, 1);
    applyStimulus(OP_SH,  12'h013, 32'h00007777, 32'h00001299, 1'b1, 1);
    applyStimulus(OP_LHU, 12'h011, 32'h0,        32'h00001299, 1'b1, 1);
    checkOutput("err_hold", {31'b0, err}, 32'd1);
    checkOutput("misaligned_we_count", 32'(weCount), 32'd4);
    checkOutput("misaligned_mem4", mem[4], 32'hDE55BEEF);
    applyStimulus(OP_LW, 12'h010, 32'h0, 32'hDE55BEEF, 1'b0, 3);

    // Abort a sub-word store with reset while it sits in RD_DATA.
    doneBefore = doneCount;
    start = 1'b1;
    op    = OP_SH;
    addr  = 12'h012;
    wdata = 32'h00001234;
    @(negedge clk);
    start = 1'b0;
    checkOutput("abort_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkReset("abort");
    checkOutput("abort_we_count", 32'(weCount), 32'd4);
    checkOutput("abort_mem4", mem[4], 32'hDE55BEEF);
    checkOutput("abort_no_done", 32'(doneCount), 32'(doneBefore));
    rst = 1'b0;
    applyStimulus(OP_LW, 12'h010, 32'h0, 32'hDE55BEEF, 1'b0, 3);

    // start held high: accepted only in IDLE, so at edges 0, 4 and 8.
    doneBefore = doneCount;
    baseCyc = cycleCnt;
    start = 1'b1;
    op    = OP_LW;
    addr  = 12'h020;
    for (int k = 0; k < 3; k++) begin
      expq.push_back('{baseCyc + 3 + 4 * k, 32'h00001299, 1'b0, tagCnt});
      tagCnt++;
    end
    repeat (10) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("held_start_dones", 32'(doneCount - doneBefore), 32'd3);
    checkOutput("queue_empty", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the word-address width of the data memory; the byte address width SHALL be ADDR_W+2.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 start  input  1  SHALL request one access; it is sampled only in IDLE.
REQ-005 op  input  3  SHALL encode the access: 000 LB, 001 LH, 010 LW, 011 SW, 100 LBU, 101 LHU, 110 SB, 111 SH.
REQ-006 addr  input  ADDR_W+2  SHALL be the byte address.
REQ-007 wdata  input  32  SHALL carry store data, with byte and halfword data in the low bits.
REQ-008 rdata  output  32  SHALL carry the extended load result.
REQ-009 done  output  1  SHALL be a one-cycle completion pulse.
REQ-010 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-011 err  output  1  SHALL flag a misaligned access and is valid with done.
REQ-012 mem_address  output  ADDR_W  SHALL be the word address to datamemory.
REQ-013 mem_dataIn  output  32  SHALL be the write word to datamemory.
REQ-014 mem_we  output  1  SHALL be the write enable to datamemory.
REQ-015 mem_dataOut  input  32  SHALL be the datamemory read word, valid one cycle after mem_address changes.

Function
REQ-016 The FSM SHALL use exactly the states IDLE, RD_WAIT, RD_DATA, WR and DONE.
REQ-017 On start in IDLE, addr[ADDR_W+1:2], addr[1:0], op and wdata SHALL be latched; mem_address SHALL equal the latched word address until the next start.
REQ-018 Aligned load: IDLE->RD_WAIT->RD_DATA->DONE->IDLE; rdata SHALL load on the RD_DATA exit edge; done SHALL be high on the third cycle after the start edge.
REQ-019 SW aligned: IDLE->WR->DONE->IDLE; mem_dataIn SHALL equal wdata in WR; done SHALL be high two cycles after the start edge.
REQ-020 SB/SH aligned: IDLE->RD_WAIT->RD_DATA->WR->DONE->IDLE (read-modify-write); the merged word SHALL be registered in RD_DATA; done SHALL be high four cycles after the start edge.
REQ-021 Byte order SHALL be big-endian: offset 0 = bits[31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]; halfword offset 0 = [31:16], 2 = [15:0].
REQ-022 Merge SHALL replace only the addressed byte or halfword with wdata[7:0] or wdata[15:0]; other bytes SHALL retain their read values.
REQ-023 LB and LH SHALL sign-extend to 32 bits; LBU and LHU SHALL zero-extend; LW SHALL pass the word unchanged.
REQ-024 mem_we SHALL be 1 only in WR, for exactly one cycle per store, and 0 otherwise.
REQ-025 Misaligned cases are LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0.
REQ-026 A misaligned access SHALL go IDLE->DONE with err=1 and done one cycle after start; it SHALL perform no memory write and leave rdata unchanged.
REQ-027 err SHALL be 0 on every aligned completion and SHALL hold its value until the next start.
REQ-028 rdata SHALL hold its value until the next successful load completes; stores SHALL NOT change rdata.
REQ-029 start while busy SHALL be ignored without queuing; start in the same cycle as DONE SHALL also be ignored.
REQ-030 Back-to-back operation: start in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-031 Asserting rst SHALL immediately force the state to IDLE and set rdata=0, done=0, busy=0, err=0, mem_we=0, mem_address=0 and mem_dataIn=0.
REQ-032 rst asserted mid-operation SHALL abort the access with no done pulse; if the abort occurs before the WR edge, no memory write SHALL occur.
REQ-033 After rst deasserts, the first rising edge SHALL be able to accept start.

Verification
REQ-034 SW addr=0x010, wdata=0xDEADBEEF, then LW addr=0x010 -> mem_we pulses once with mem_address=4; the LW gives rdata=0xDEADBEEF, err=0, done at start+3.
REQ-035 Memory word 4=0xDEADBEEF, SB addr=0x011, wdata=0x55, then LW addr=0x010 -> rdata=0xDE55BEEF; the SB gives done at start+4.
REQ-036 Word 4=0xDE55BEEF, LB addr=0x011 -> 0x00000055; LH addr=0x010 -> 0xFFFFDE55; LHU addr=0x010 -> 0x0000DE55; LBU addr=0x013 -> 0x000000EF.
REQ-037 LW addr=0x012 and SH addr=0x013 -> done at start+1 with err=1, mem_we never asserted, rdata unchanged.
REQ-038 SH addr=0x012, wdata=0x1234, with rst pulsed while in RD_DATA -> no done pulse, mem_we stays 0, word 4 unchanged, and all outputs read their reset values.
REQ-039 start held high for 10 cycles during an LW -> exactly one done pulse per accepted start; a new access is accepted only in IDLE.
